// File: rtl/fifo_arb_pkg.sv
// +--------------------------------------------------------------------+
// | fifo_arb_pkg : shared types and helpers for fifo_wr_arbiter         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic {IDLE, XFER} arb_state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    // Increment with explicit wrap so non-power-of-two NREQ stays in range.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +--------------------------------------------------------------------+
// | rr_pick : combinational round-robin search starting at rr_ptr       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] pick_o,
    output logic            found_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        pick_o  = '0;
        found_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_i} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found_o     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// +--------------------------------------------------------------------+
// | fifo_wr_arbiter : frame-granular round-robin arbiter for FIFO wport |
// | Optional stall abort: define FIFO_ARB_TIMEOUT_EN                    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       valid,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       ready,
    input  logic                  full,
    output logic                  w_en,
    output logic [WIDTH-1:0]      data_out,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int PW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] pick;
    logic            found;
    logic [PW-1:0]   pick_idx;
    logic            valid_g;
    logic            last_g;
    logic            accept;
    logic            abort;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .pick_o   (pick),
        .found_o  (found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // Write path is combinational on full so a write can never land on a full FIFO.
    assign valid_g  = valid[gidx_q];
    assign last_g   = last[gidx_q];
    assign accept   = (state_q == XFER) && valid_g && !full;
    assign ready    = accept ? grant_q : '0;
    assign w_en     = accept;
    assign data_out = (state_q == XFER) ? data[gidx_q*WIDTH +: WIDTH] : '0;
    assign grant    = grant_q;
    assign busy     = (state_q == XFER);

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);

    logic [CW-1:0] stall_q, stall_d;
    logic [CW-1:0] stall_inc;

    assign stall_inc = stall_q + 1'b1;

    // Full-stalled beats (valid high) neither count nor clear the stall run.
    always_comb begin
        stall_d = stall_q;
        abort   = 1'b0;
        if (state_q != XFER || accept) begin
            stall_d = '0;
        end else if (!valid_g) begin
            if (stall_inc == CW'(TIMEOUT)) begin
                abort   = 1'b1;
                stall_d = '0;
            end else begin
                stall_d = stall_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign timeout_err = abort;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = XFER;
                    grant_d = pick;
                    gidx_d  = pick_idx;
                end
            end
            XFER: begin
                if ((accept && last_g) || abort) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = PW'(rr_next(32'(gidx_q), NREQ));
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_fifo_wr_arbiter : directed self-checking bench for the arbiter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  req, valid, last, ready, grant;
    logic [31:0] data;
    logic        full, w_en, busy, timeout_err;
    logic [7:0]  data_out;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(
        .NREQ    (4),
        .WIDTH   (8),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .req         (req),
        .valid       (valid),
        .last        (last),
        .data        (data),
        .ready       (ready),
        .full        (full),
        .w_en        (w_en),
        .data_out    (data_out),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int lane, input logic [7:0] val, input logic is_last);
        valid = '0;
        last  = '0;
        data  = '0;
        valid[lane] = 1'b1;
        last[lane]  = is_last;
        data[lane*8 +: 8] = val;
    endtask

    task automatic clear_beat();
        valid = '0;
        last  = '0;
        data  = '0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        req = '0; full = 1'b0;
        clear_beat();
        @(posedge clk);
        #3 arst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        req = '0; full = 1'b0;
        clear_beat();
        #2;
        checks++;
        if ({grant, w_en, ready, busy, timeout_err, data_out} !== 19'd0) begin
            failures++;
            $display("FAIL reset_state got grant=%b w_en=%b ready=%b busy=%b to=%b dout=%h expected all zero",
                     grant, w_en, ready, busy, timeout_err, data_out);
        end
        @(posedge clk);
        #3 arst_n = 1'b1;
        cyc();
        checks++;
        if ({grant, busy} !== 5'd0) begin
            failures++;
            $display("FAIL reset_release got grant=%b busy=%b expected 0000/0", grant, busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] beats [4];
        beats = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        req = 4'b0001;
        #1;
        checks++;
        if ({grant, busy} !== 5'd0) begin
            failures++;
            $display("FAIL single_idle got grant=%b busy=%b expected 0000/0", grant, busy);
        end
        cyc();
        req = '0;
        for (int b = 0; b < 4; b++) begin
            set_beat(0, beats[b], b == 3);
            #1;
            checks++;
            if ({grant, busy, w_en, ready, data_out} !== {4'b0001, 1'b1, 1'b1, 4'b0001, beats[b]}) begin
                failures++;
                $display("FAIL single_beat%0d got grant=%b busy=%b w_en=%b ready=%b dout=%h expected 0001/1/1/0001/%h",
                         b, grant, busy, w_en, ready, data_out, beats[b]);
            end
            cyc();
        end
        clear_beat();
        #1;
        checks++;
        if ({grant, busy, w_en, data_out} !== 14'd0) begin
            failures++;
            $display("FAIL single_end got grant=%b busy=%b w_en=%b dout=%h expected idle zeros",
                     grant, busy, w_en, data_out);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] ev;
        do_reset();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            clear_beat();
            #1;
            checks++;
            if ({grant, busy, ready, w_en} !== 10'd0) begin
                failures++;
                $display("FAIL fair_gap%0d got grant=%b busy=%b ready=%b w_en=%b expected idle",
                         f, grant, busy, ready, w_en);
            end
            cyc();
            for (int b = 0; b < 2; b++) begin
                valid = 4'b1111;
                last  = (b == 1) ? 4'b1111 : 4'b0000;
                for (int i = 0; i < 4; i++) data[i*8 +: 8] = 8'(16 * (i + 1) + b);
                ev = 8'(16 * ((f % 4) + 1) + b);
                #1;
                checks++;
                if ({grant, ready, w_en, data_out} !== {4'(1 << (f % 4)), 4'(1 << (f % 4)), 1'b1, ev}) begin
                    failures++;
                    $display("FAIL fair_f%0d_b%0d got grant=%b ready=%b w_en=%b dout=%h expected grant=%b dout=%h",
                             f, b, grant, ready, w_en, data_out, 4'(1 << (f % 4)), ev);
                end
                cyc();
            end
        end
        req = '0;
        clear_beat();
        #1;
        cyc();
    endtask

    task automatic test_full();
        req = 4'b0010;
        #1;
        cyc();
        req = '0;
        set_beat(1, 8'h51, 1'b0);
        #1;
        checks++;
        if ({grant, w_en, data_out} !== {4'b0010, 1'b1, 8'h51}) begin
            failures++;
            $display("FAIL full_beat0 got grant=%b w_en=%b dout=%h expected 0010/1/51", grant, w_en, data_out);
        end
        cyc();
        set_beat(1, 8'h52, 1'b0);
        full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if ({grant, busy, w_en, ready} !== {4'b0010, 1'b1, 1'b0, 4'b0000}) begin
                failures++;
                $display("FAIL full_hold%0d got grant=%b busy=%b w_en=%b ready=%b expected 0010/1/0/0000",
                         s, grant, busy, w_en, ready);
            end
            cyc();
        end
        full = 1'b0;
        for (int b = 0; b < 3; b++) begin
            set_beat(1, 8'h52 + 8'(b), b == 2);
            #1;
            checks++;
            if ({w_en, ready, data_out} !== {1'b1, 4'b0010, 8'h52 + 8'(b)}) begin
                failures++;
                $display("FAIL full_resume%0d got w_en=%b ready=%b dout=%h expected 1/0010/%h",
                         b, w_en, ready, data_out, 8'h52 + 8'(b));
            end
            cyc();
        end
        clear_beat();
        #1;
        checks++;
        if ({grant, busy} !== 5'd0) begin
            failures++;
            $display("FAIL full_end got grant=%b busy=%b expected 0000/0", grant, busy);
        end
    endtask

    task automatic test_req_drop();
        req = 4'b0100;
        #1;
        cyc();
        for (int b = 0; b < 4; b++) begin
            if (b >= 1) req = 4'b0001;
            set_beat(2, 8'h61 + 8'(b), b == 3);
            #1;
            checks++;
            if ({grant, w_en, data_out} !== {4'b0100, 1'b1, 8'h61 + 8'(b)}) begin
                failures++;
                $display("FAIL drop_beat%0d got grant=%b w_en=%b dout=%h expected 0100/1/%h",
                         b, grant, w_en, data_out, 8'h61 + 8'(b));
            end
            cyc();
        end
        clear_beat();
        #1;
        checks++;
        if ({grant, busy} !== 5'd0) begin
            failures++;
            $display("FAIL drop_gap got grant=%b busy=%b expected 0000/0", grant, busy);
        end
        cyc();
        set_beat(0, 8'h71, 1'b1);
        req = '0;
        #1;
        checks++;
        if ({grant, w_en, data_out} !== {4'b0001, 1'b1, 8'h71}) begin
            failures++;
            $display("FAIL drop_next got grant=%b w_en=%b dout=%h expected 0001/1/71", grant, w_en, data_out);
        end
        cyc();
        clear_beat();
        #1;
        checks++;
        if ({grant, busy} !== 5'd0) begin
            failures++;
            $display("FAIL single_beat_frame got grant=%b busy=%b expected 0000/0", grant, busy);
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b0010;
        #1;
        cyc();
        req = '0;
        for (int b = 0; b < 2; b++) begin
            set_beat(1, 8'h81 + 8'(b), 1'b0);
            #1;
            cyc();
        end
        set_beat(1, 8'h83, 1'b0);
        #1;
        checks++;
        if ({grant, w_en} !== {4'b0010, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_pre got grant=%b w_en=%b expected 0010/1", grant, w_en);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if ({grant, w_en, busy, ready, data_out} !== 18'd0) begin
            failures++;
            $display("FAIL rstmid_async got grant=%b w_en=%b busy=%b ready=%b dout=%h expected all zero",
                     grant, w_en, busy, ready, data_out);
        end
        clear_beat();
        @(posedge clk);
        #3 arst_n = 1'b1;
        cyc();
        req = 4'b1001;
        #1;
        cyc();
        req = '0;
        set_beat(0, 8'h91, 1'b1);
        #1;
        checks++;
        if ({grant, w_en, data_out} !== {4'b0001, 1'b1, 8'h91}) begin
            failures++;
            $display("FAIL rstmid_ptr got grant=%b w_en=%b dout=%h expected 0001/1/91", grant, w_en, data_out);
        end
        cyc();
        clear_beat();
        #1;
    endtask

    task automatic test_timeout();
`ifdef FIFO_ARB_TIMEOUT_EN
        req = 4'b0110;
        #1;
        cyc();
        clear_beat();
        for (int s = 1; s <= 8; s++) begin
            #1;
            checks++;
            if ({grant, w_en, timeout_err} !== {4'b0010, 1'b0, (s == 8)}) begin
                failures++;
                $display("FAIL timeout_s%0d got grant=%b w_en=%b to=%b expected 0010/0/%0d",
                         s, grant, w_en, timeout_err, (s == 8));
            end
            cyc();
        end
        #1;
        checks++;
        if ({grant, busy, timeout_err} !== 6'd0) begin
            failures++;
            $display("FAIL timeout_idle got grant=%b busy=%b to=%b expected 0000/0/0", grant, busy, timeout_err);
        end
        cyc();
        req = '0;
        set_beat(2, 8'hA5, 1'b1);
        #1;
        checks++;
        if ({grant, w_en, data_out} !== {4'b0100, 1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL timeout_next got grant=%b w_en=%b dout=%h expected 0100/1/a5", grant, w_en, data_out);
        end
        cyc();
        clear_beat();
        #1;
`else
        req = 4'b0010;
        #1;
        cyc();
        req = '0;
        clear_beat();
        for (int s = 0; s < 12; s++) begin
            #1;
            checks++;
            if ({grant, busy, w_en, timeout_err} !== {4'b0010, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold%0d got grant=%b busy=%b w_en=%b to=%b expected 0010/1/0/0",
                         s, grant, busy, w_en, timeout_err);
            end
            cyc();
        end
        set_beat(1, 8'hB1, 1'b1);
        #1;
        checks++;
        if ({w_en, data_out} !== {1'b1, 8'hB1}) begin
            failures++;
            $display("FAIL stall_release got w_en=%b dout=%h expected 1/b1", w_en, data_out);
        end
        cyc();
        clear_beat();
        #1;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_req_drop();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
